// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the NZCV status flags, evaluates each
// instruction's condition field and gates the write/redirect controls.
module cond_unit #(
  parameter logic [3:0]  ResetFlags = 4'b0000,
  parameter int unsigned CountWidth = 16
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Valid,
  input  logic                  i_Stall,
  input  logic [3:0]            i_Cond,
  input  logic [3:0]            i_ALU_Flags,
  input  logic [1:0]            i_FlagWrite,
  input  logic                  i_RegWrite,
  input  logic                  i_MemWrite,
  input  logic                  i_PCSrc,
  input  logic                  i_Clear_Counts,
  output logic                  o_CondEx,
  output logic                  o_RegWrite,
  output logic                  o_MemWrite,
  output logic                  o_PCSrc,
  output logic [3:0]            o_Flags,
  output logic [CountWidth-1:0] o_Count_Exec,
  output logic [CountWidth-1:0] o_Count_Skip
);

  localparam logic [CountWidth-1:0] CountOne = {{(CountWidth-1){1'b0}}, 1'b1};

  logic [3:0]            flags_q, flags_d;
  logic [CountWidth-1:0] countExec_q, countExec_d;
  logic [CountWidth-1:0] countSkip_q, countSkip_d;
  logic                  flagN, flagZ, flagC, flagV;
  logic                  condEx;
  logic                  commit;

  assign {flagN, flagZ, flagC, flagV} = flags_q;
  assign commit = i_Valid & ~i_Stall;

  // Conditions are always judged against the committed flags, never the ALU's.
  always_comb begin
    condEx = 1'b0;
    case (i_Cond)
      4'b0000: condEx = flagZ;
      4'b0001: condEx = ~flagZ;
      4'b0010: condEx = flagC;
      4'b0011: condEx = ~flagC;
      4'b0100: condEx = flagN;
      4'b0101: condEx = ~flagN;
      4'b0110: condEx = flagV;
      4'b0111: condEx = ~flagV;
      4'b1000: condEx = flagC & ~flagZ;
      4'b1001: condEx = ~flagC | flagZ;
      4'b1010: condEx = (flagN == flagV);
      4'b1011: condEx = (flagN != flagV);
      4'b1100: condEx = ~flagZ & (flagN == flagV);
      4'b1101: condEx = flagZ | (flagN != flagV);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  assign o_CondEx   = condEx;
  assign o_RegWrite = i_RegWrite & condEx & commit;
  assign o_MemWrite = i_MemWrite & condEx & commit;
  assign o_PCSrc    = i_PCSrc & condEx & commit;

  always_comb begin
    flags_d     = flags_q;
    countExec_d = countExec_q;
    countSkip_d = countSkip_q;
    if (commit && condEx) begin
      if (i_FlagWrite[1]) flags_d[3:2] = i_ALU_Flags[3:2];
      if (i_FlagWrite[0]) flags_d[1:0] = i_ALU_Flags[1:0];
    end
    // Clear wins over a same-cycle increment; counters stick at all-ones.
    if (i_Clear_Counts) begin
      countExec_d = '0;
      countSkip_d = '0;
    end else if (commit) begin
      if (condEx) begin
        if (~&countExec_q) countExec_d = countExec_q + CountOne;
      end else begin
        if (~&countSkip_q) countSkip_d = countSkip_q + CountOne;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      flags_q     <= ResetFlags;
      countExec_q <= '0;
      countSkip_q <= '0;
    end else begin
      flags_q     <= flags_d;
      countExec_q <= countExec_d;
      countSkip_q <= countSkip_d;
    end
  end

  assign o_Flags      = flags_q;
  assign o_Count_Exec = countExec_q;
  assign o_Count_Skip = countSkip_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model.
module tb_cond_unit;

  localparam int         CW       = 6;
  localparam logic [3:0] RF       = 4'b0000;
  localparam int         MaxCount = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid, stall, regWrite, memWrite, pcSrc, clr;
  logic [3:0]    cond, aluFlags;
  logic [1:0]    flagWrite;
  logic          condExO, regWriteO, memWriteO, pcSrcO;
  logic [3:0]    flagsO;
  logic [CW-1:0] countExecO, countSkipO;

  int assertCount = 0;
  int failCount   = 0;

  logic [3:0] mFlags;
  int         mExec, mSkip;
  logic       mPass;

  cond_unit #(.ResetFlags(RF), .CountWidth(CW)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Valid(valid), .i_Stall(stall),
    .i_Cond(cond), .i_ALU_Flags(aluFlags), .i_FlagWrite(flagWrite),
    .i_RegWrite(regWrite), .i_MemWrite(memWrite), .i_PCSrc(pcSrc),
    .i_Clear_Counts(clr), .o_CondEx(condExO), .o_RegWrite(regWriteO),
    .o_MemWrite(memWriteO), .o_PCSrc(pcSrcO), .o_Flags(flagsO),
    .o_Count_Exec(countExecO), .o_Count_Skip(countSkipO)
  );

  always #5 clk = ~clk;

  // Condition table expressed directly on named flag bits.
  function automatic logic passes(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [3:0] c,
                               input logic [3:0] alu, input logic [1:0] fw,
                               input logic rw, input logic mw, input logic pc,
                               input logic cl);
    valid = v; stall = s; cond = c; aluFlags = alu; flagWrite = fw;
    regWrite = rw; memWrite = mw; pcSrc = pc; clr = cl;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural flags and saturating counts.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mFlags = RF;
      mExec  = 0;
      mSkip  = 0;
    end else begin
      mPass = passes(mFlags, cond);
      if (valid && !stall) begin
        if (mPass && flagWrite[1]) mFlags[3:2] = aluFlags[3:2];
        if (mPass && flagWrite[0]) mFlags[1:0] = aluFlags[1:0];
      end
      if (clr) begin
        mExec = 0;
        mSkip = 0;
      end else if (valid && !stall) begin
        if (mPass) mExec = (mExec < MaxCount) ? mExec + 1 : MaxCount;
        else       mSkip = (mSkip < MaxCount) ? mSkip + 1 : MaxCount;
      end
    end
  end

  always @(negedge clk) begin
    logic expCond, doCommit;
    expCond  = passes(mFlags, cond);
    doCommit = valid && !stall;
    checkOutput("condEx",   condExO,   expCond);
    checkOutput("regWrite", regWriteO, regWrite && expCond && doCommit);
    checkOutput("memWrite", memWriteO, memWrite && expCond && doCommit);
    checkOutput("pcSrc",    pcSrcO,    pcSrc && expCond && doCommit);
    checkOutput("flags",    flagsO,    mFlags);
    checkOutput("countExec", countExecO, mExec);
    checkOutput("countSkip", countSkipO, mSkip);
  end

  initial begin
    logic [3:0] signedConds [4];
    logic       signedExp   [4];
    signedConds = '{4'hB, 4'hA, 4'hC, 4'hD};
    signedExp   = '{1'b1, 1'b0, 1'b0, 1'b1};

    applyStimulus(0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checkOutput("resetFlags", flagsO, 4'b0000);
    checkOutput("resetExec", countExecO, 0);
    checkOutput("resetSkip", countSkipO, 0);

    nextCycle();
    rst = 1'b0;
    applyStimulus(1, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("eqAfterReset", condExO, 0);
    checkOutput("eqRegWrite", regWriteO, 0);

    nextCycle();
    applyStimulus(1, 0, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("skipAfterEq", countSkipO, 1);
    checkOutput("alPasses", condExO, 1);

    nextCycle();
    applyStimulus(1, 0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("eqMemWrite", memWriteO, 1);
    checkOutput("subsFlags", flagsO, 4'b0100);
    checkOutput("execAfterSubs", countExecO, 1);

    nextCycle();
    applyStimulus(1, 0, 4'hE, 4'b1010, 2'b11, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 0, 4'hE, 4'b0101, 2'b10, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("flagsPre", flagsO, 4'b1010);
    nextCycle();
    applyStimulus(1, 0, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("partialFlags", flagsO, 4'b0110);

    for (int i = 0; i < 4; i++) begin
      nextCycle();
      applyStimulus(0, 0, signedConds[i], 4'h0, 2'b00, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput($sformatf("signedNV_%0h", signedConds[i]), condExO, signedExp[i]);
    end

    nextCycle();
    applyStimulus(1, 0, 4'hE, 4'b1001, 2'b11, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 4'hC, 4'h0, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("gtPasses", condExO, 1);
    checkOutput("flagsBeforeStall", flagsO, 4'b1001);

    nextCycle();
    applyStimulus(1, 1, 4'hE, 4'b0110, 2'b11, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stallRegWrite", regWriteO, 0);
      checkOutput("stallFlags", flagsO, 4'b1001);
      checkOutput("stallExec", countExecO, 6);
      nextCycle();
    end
    stall = 1'b0;
    @(negedge clk);
    checkOutput("releaseRegWrite", regWriteO, 1);
    nextCycle();
    applyStimulus(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("releaseExec", countExecO, 7);
    checkOutput("releaseFlags", flagsO, 4'b0110);

    nextCycle();
    applyStimulus(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    repeat (60) nextCycle();
    @(negedge clk);
    checkOutput("saturated", countExecO, MaxCount);
    nextCycle();
    @(negedge clk);
    checkOutput("staysSaturated", countExecO, MaxCount);
    checkOutput("skipUnchanged", countSkipO, 1);
    nextCycle();
    clr = 1'b1;
    nextCycle();
    applyStimulus(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("clearExec", countExecO, 0);
    checkOutput("clearSkip", countSkipO, 0);

    nextCycle();
    applyStimulus(1, 0, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("flagsAllSet", flagsO, 4'b1111);
    checkOutput("execOne", countExecO, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncResetFlags", flagsO, RF);
    checkOutput("asyncResetExec", countExecO, 0);
    nextCycle();
    rst = 1'b0;

    repeat (600) begin
      applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 63) == 0);
      nextCycle();
    end
    rst = 1'b0;
    applyStimulus(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    nextCycle();
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
